// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : run_monitor
//  Brief    : Tracks one CPU run (cycles, retires) and records why it ended.
//  Revision : 1.0
// ============================================================================
module run_monitor #(
   parameter int MAX_CYCLES = 1000,
   parameter int WDOG_LIMIT = 256,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          retire,
   input  logic          halt,
   output logic [CW-1:0] cycles,
   output logic [CW-1:0] retired,
   output logic          running,
   output logic          done,
   output logic [1:0]    status
);

   localparam int IW = $clog2(WDOG_LIMIT + 1);

   localparam logic [1:0] c_ST_NONE = 2'b00;
   localparam logic [1:0] c_ST_HALT = 2'b01;
   localparam logic [1:0] c_ST_LIM  = 2'b10;
   localparam logic [1:0] c_ST_WDOG = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cycles;
   logic [CW-1:0] r_retired;
   logic [IW-1:0] r_idle;
   logic          r_running;
   logic          r_done;
   logic [1:0]    r_status;

   logic [CW-1:0] w_cyc_nxt;
   logic [CW-1:0] w_ret_nxt;
   logic [IW-1:0] w_idle_nxt;
   logic          w_ret_sat;
   logic          w_hit_max;
   logic          w_hit_wdog;

   // Next-value terms for a run edge; termination is judged on the updated counts.
   assign w_cyc_nxt  = r_cycles + 1'b1;
   assign w_ret_sat  = &r_retired;
   assign w_ret_nxt  = (retire && !w_ret_sat) ? r_retired + 1'b1 : r_retired;
   assign w_idle_nxt = retire ? '0 : r_idle + 1'b1;
   assign w_hit_max  = (w_cyc_nxt == CW'(MAX_CYCLES));
   assign w_hit_wdog = (w_idle_nxt == IW'(WDOG_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cycles  <= '0;
         r_retired <= '0;
         r_idle    <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_status  <= c_ST_NONE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state   <= S_RUN;
                  r_cycles  <= '0;
                  r_retired <= '0;
                  r_idle    <= '0;
                  r_running <= 1'b1;
                  r_done    <= 1'b0;
                  r_status  <= c_ST_NONE;
               end
            end
            S_RUN: begin
               r_cycles  <= w_cyc_nxt;
               r_retired <= w_ret_nxt;
               r_idle    <= w_idle_nxt;
               // Priority: halt, then cycle budget, then watchdog.
               if (halt || w_hit_max || w_hit_wdog) begin
                  r_state   <= S_DONE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
                  if (halt)
                     r_status <= c_ST_HALT;
                  else if (w_hit_max)
                     r_status <= c_ST_LIM;
                  else
                     r_status <= c_ST_WDOG;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_running <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign cycles  = r_cycles;
   assign retired = r_retired;
   assign running = r_running;
   assign done    = r_done;
   assign status  = r_status;

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_monitor
//  Brief    : Directed self-checking bench for run_monitor (MAX=20, WDOG=5).
//  Revision : 1.0
// ============================================================================
module tb_run_monitor;

   localparam int CW = 16;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          retire;
   logic          halt;
   logic [CW-1:0] cycles;
   logic [CW-1:0] retired;
   logic          running;
   logic          done;
   logic [1:0]    status;

   int n_vec;
   int n_err;

   run_monitor #(
      .MAX_CYCLES (20),
      .WDOG_LIMIT (5),
      .CW         (CW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .retire  (retire),
      .halt    (halt),
      .cycles  (cycles),
      .retired (retired),
      .running (running),
      .done    (done),
      .status  (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view: {running, done, status, cycles, retired}
   function automatic logic [35:0] pk(input logic r, input logic d, input logic [1:0] s,
                                      input int c, input int t);
      return {r, d, s, c[15:0], t[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [35:0] exp);
      logic [35:0] obs;
      obs = {running, done, status, cycles, retired};
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed run=%b done=%b st=%b cyc=%0d ret=%0d, expected run=%b done=%b st=%b cyc=%0d ret=%0d",
                tag, obs[35], obs[34], obs[33:32], obs[31:16], obs[15:0],
                exp[35], exp[34], exp[33:32], exp[31:16], exp[15:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start", pk(1'b1, 1'b0, 2'b00, 0, 0));
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      retire = 1'b0;
      halt   = 1'b0;

      // Reset and idle hold
      step();
      step();
      chk("reset", pk(1'b0, 1'b0, 2'b00, 0, 0));
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_hold", pk(1'b0, 1'b0, 2'b00, 0, 0));
      end

      // Halt at run edge 8
      do_start();
      retire = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("halt_run", pk(1'b1, 1'b0, 2'b00, k, k));
      end
      halt = 1'b1;
      step();
      chk("halt_end", pk(1'b0, 1'b1, 2'b01, 8, 8));
      for (int i = 0; i < 10; i++) begin
         halt = i[0];
         step();
         chk("done_hold", pk(1'b0, 1'b1, 2'b01, 8, 8));
      end
      halt = 1'b0;

      // Cycle limit at run edge 20; a start pulse mid-run is ignored
      do_start();
      retire = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         start = (k == 3);
         step();
         chk("limit_run", pk(1'b1, 1'b0, 2'b00, k, k));
      end
      start = 1'b0;
      step();
      chk("limit_end", pk(1'b0, 1'b1, 2'b10, 20, 20));

      // Watchdog at run edge 5
      do_start();
      retire = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("wdog_run", pk(1'b1, 1'b0, 2'b00, k, 0));
      end
      step();
      chk("wdog_end", pk(1'b0, 1'b1, 2'b11, 5, 0));

      // Alternate retires; halt coincides with the cycle limit at edge 20
      do_start();
      for (int k = 1; k <= 19; k++) begin
         retire = k[0];
         step();
         chk("alt_run", pk(1'b1, 1'b0, 2'b00, k, (k + 1) / 2));
      end
      retire = 1'b0;
      halt   = 1'b1;
      step();
      chk("halt_vs_limit", pk(1'b0, 1'b1, 2'b01, 20, 10));
      halt = 1'b0;

      // Asynchronous reset mid-run
      do_start();
      retire = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("pre_reset", pk(1'b1, 1'b0, 2'b00, k, k));
      end
      #2 rst_n = 1'b0;
      #1 chk("async_reset", pk(1'b0, 1'b0, 2'b00, 0, 0));
      #2 rst_n = 1'b1;
      retire = 1'b0;
      step();
      chk("post_reset_idle", pk(1'b0, 1'b0, 2'b00, 0, 0));

      // Clean run after reset
      do_start();
      retire = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         chk("clean_run", pk(1'b1, 1'b0, 2'b00, k, k));
      end
      retire = 1'b0;
      for (int k = 3; k <= 6; k++) begin
         step();
         chk("clean_idle", pk(1'b1, 1'b0, 2'b00, k, 2));
      end
      step();
      chk("clean_wdog", pk(1'b0, 1'b1, 2'b11, 7, 2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
